regfile_wb_sched: RTL and testbench

- Write-back scheduler and hazard scoreboard for the 32x32 register file (single write port Wr/D/We, two read ports Ra/Rb).
- Arbitrates two write-back requesters (port A: ALU, port B: load/multiply unit) onto the single write port using round-robin.
- Keeps a per-register busy bit so decode can stall on pending writes.
- Sits between execute/memory stages and the register file; its Wr/D/We outputs drive the register file's write inputs directly.

---
 rtl/regfile_wb_sched_pkg.sv | 16 +
 rtl/regfile_wb_sched_rr_arb2.sv | 42 ++++
 rtl/regfile_wb_sched.sv | 97 +++++++++
 tb/tb_regfile_wb_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared register-file geometry and write-back arbitration types.
// Also used by the register file and the decoder.
package regfile_wb_sched_pkg;

  localparam int unsigned RF_DW   = 32;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned RF_NREG = 1 << RF_AW;
  localparam int unsigned RF_R0   = 0;

  // Round-robin pointer: which requester wins the next conflict.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_side_e;

endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, pointer moves only
// when both requesters are valid.
module rr_arb2
  import regfile_wb_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  rr_side_e ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= RR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // On a conflict the named side wins and the pointer flips to the other.
  always_comb begin
    gnt_c_o = 2'b00;
    ptr_d   = ptr_q;
    unique case (req_i)
      2'b01: gnt_c_o = 2'b01;
      2'b10: gnt_c_o = 2'b10;
      2'b11: begin
        if (ptr_q == RR_A) begin
          gnt_c_o = 2'b01;
          ptr_d   = RR_B;
        end else begin
          gnt_c_o = 2'b10;
          ptr_d   = RR_A;
        end
      end
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU and load/mul write-backs onto the single
// register-file write port and tracks per-register pending-write busy bits.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          A_valid,
  input  logic [AW-1:0] A_reg,
  input  logic [DW-1:0] A_data,
  output logic          A_ready,
  input  logic          B_valid,
  input  logic [AW-1:0] B_reg,
  input  logic [DW-1:0] B_data,
  output logic          B_ready,
  input  logic          Rsv_en,
  input  logic [AW-1:0] Rsv_reg,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic          Ra_busy,
  output logic          Rb_busy,
  output logic [AW-1:0] Wr,
  output logic [DW-1:0] D,
  output logic          We
);

  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] R0 = AW'(RF_R0);

  logic [1:0]      gnt;
  logic [AW-1:0]   wr_q, wr_d;
  logic [DW-1:0]   d_q, d_d;
  logic            we_q, we_d;
  logic [NREG-1:0] busy_q, busy_d;

  rr_arb2 u_arb (
    .clk_i   (Clk),
    .rst_i   (Clr),
    .req_i   ({B_valid, A_valid}),
    .gnt_c_o (gnt)
  );

  assign A_ready = gnt[0];
  assign B_ready = gnt[1];

  // Accepted write goes out next cycle; r0 writes are swallowed with We low.
  always_comb begin
    wr_d = wr_q;
    d_d  = d_q;
    we_d = 1'b0;
    if (gnt[1]) begin
      wr_d = B_reg;
      d_d  = B_data;
      we_d = (B_reg != R0);
    end else if (gnt[0]) begin
      wr_d = A_reg;
      d_d  = A_data;
      we_d = (A_reg != R0);
    end
  end

  // Commit clears first so a same-edge reservation of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[wr_q] = 1'b0;
    end
    if (Rsv_en && (Rsv_reg != R0)) begin
      busy_d[Rsv_reg] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      wr_q   <= '0;
      d_q    <= '0;
      we_q   <= 1'b0;
      busy_q <= '0;
    end else begin
      wr_q   <= wr_d;
      d_q    <= d_d;
      we_q   <= we_d;
      busy_q <= busy_d;
    end
  end

  assign Ra_busy = (Ra != R0) && busy_q[Ra];
  assign Rb_busy = (Rb != R0) && busy_q[Rb];

  assign Wr = wr_q;
  assign D  = d_q;
  assign We = we_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the scheduling rules.
module tb_regfile_wb_sched;
  import regfile_wb_sched_pkg::*;

  localparam int unsigned AW   = RF_AW;
  localparam int unsigned DW   = RF_DW;
  localparam int unsigned NREG = RF_NREG;

  logic          Clk = 1'b0;
  logic          Clr = 1'b0;
  logic          A_valid = 1'b0, B_valid = 1'b0, Rsv_en = 1'b0;
  logic [AW-1:0] A_reg = '0, B_reg = '0, Rsv_reg = '0, Ra = '0, Rb = '0;
  logic [DW-1:0] A_data = '0, B_data = '0;
  logic          A_ready, B_ready, Ra_busy, Rb_busy, We;
  logic [AW-1:0] Wr;
  logic [DW-1:0] D;

  regfile_wb_sched dut (
    .Clk(Clk), .Clr(Clr),
    .A_valid(A_valid), .A_reg(A_reg), .A_data(A_data), .A_ready(A_ready),
    .B_valid(B_valid), .B_reg(B_reg), .B_data(B_data), .B_ready(B_ready),
    .Rsv_en(Rsv_en), .Rsv_reg(Rsv_reg), .Ra(Ra), .Rb(Rb),
    .Ra_busy(Ra_busy), .Rb_busy(Rb_busy), .Wr(Wr), .D(D), .We(We)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_init = 1'b0;
  bit            m_a_turn;
  bit            m_busy [NREG];
  bit            m_we;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_d;
  bit            m_idle_since_rst;
  bit            last_ga, last_gb;

  // One clock cycle: drive inputs, check against the model mid-cycle, advance model at the edge.
  task automatic cycle(input bit clr, input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                       input bit rsv, input logic [AW-1:0] rr,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    bit ga, gb;
    Clr = clr; A_valid = av; A_reg = ar; A_data = ad;
    B_valid = bv; B_reg = br; B_data = bd;
    Rsv_en = rsv; Rsv_reg = rr; Ra = ra; Rb = rb;
    ga = av && (!bv || m_a_turn);
    gb = bv && !ga;
    #3;
    if (m_init) begin
      check_eq("A_ready", A_ready, ga);
      check_eq("B_ready", B_ready, gb);
      check_eq("Ra_busy", Ra_busy, (ra != 0) && m_busy[ra]);
      check_eq("Rb_busy", Rb_busy, (rb != 0) && m_busy[rb]);
      check_eq("We", We, m_we);
      if (m_we || m_idle_since_rst) begin
        check_eq("Wr", Wr, m_wr);
        check_eq("D", D, m_d);
      end
    end
    @(posedge Clk);
    if (clr) begin
      m_init = 1'b1;
      m_a_turn = 1'b1;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_wr = '0; m_d = '0;
      m_idle_since_rst = 1'b1;
    end else begin
      if (m_we) m_busy[m_wr] = 1'b0;
      if (rsv && rr != 0) m_busy[rr] = 1'b1;
      if (av && bv) m_a_turn = gb;
      if (ga || gb) begin
        m_wr = ga ? ar : br;
        m_d  = ga ? ad : bd;
        m_we = (m_wr != 0);
        m_idle_since_rst = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end
    last_ga = ga; last_gb = gb;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    cycle(0, 0, '0, '0, 0, '0, '0, 0, '0, ra, rb);
  endtask

  task automatic sweep_busy();
    for (int i = 0; i < int'(NREG); i += 2) idle(AW'(i), AW'(i + 1));
  endtask

  task automatic reset2();
    cycle(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0);
    cycle(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0);
  endtask

  initial begin
    bit            av, bv;
    logic [AW-1:0] ar, br;
    logic [DW-1:0] ad, bd;

    @(posedge Clk); #1;
    reset2();
    check_eq("rst_We", We, 1'b0);
    check_eq("rst_Wr", Wr, '0);
    check_eq("rst_D", D, '0);
    sweep_busy();

    // Single write from A
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, '0, '0);
    check_eq("single_We", We, 1'b1);
    check_eq("single_Wr", Wr, 5'd5);
    check_eq("single_D", D, 32'hDEADBEEF);
    idle('0, '0);
    check_eq("single_We_drop", We, 1'b0);
    idle('0, '0);

    // Conflict after reset: A, B, A
    reset2();
    cycle(0, 1, 5'd3, 32'h3333, 1, 5'd4, 32'h4444, 0, '0, '0, '0);
    check_eq("cfl1_Wr", Wr, 5'd3);
    cycle(0, 1, 5'd3, 32'h3333, 1, 5'd4, 32'h4444, 0, '0, '0, '0);
    check_eq("cfl2_Wr", Wr, 5'd4);
    cycle(0, 1, 5'd3, 32'h3333, 1, 5'd4, 32'h4444, 0, '0, '0, '0);
    check_eq("cfl3_Wr", Wr, 5'd3);
    idle('0, '0);
    idle('0, '0);

    // Scoreboard: reserve r7, write it, watch it clear
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd7, 5'd7, '0);
    idle(5'd7, '0);
    cycle(0, 1, 5'd7, 32'h77, 0, '0, '0, 0, '0, 5'd7, '0);
    idle(5'd7, '0);
    check_eq("sb_busy_gone_next", m_busy[7], 1'b0);
    idle(5'd7, '0);

    // Set wins: reserve r9, write r9, re-reserve r9 on the commit edge
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd9, '0, 5'd9);
    cycle(0, 1, 5'd9, 32'h99, 0, '0, '0, 0, '0, '0, 5'd9);
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd9, '0, 5'd9);
    idle('0, 5'd9);
    check_eq("setwins_Rb_busy", Rb_busy, 1'b1);

    // r0 write from B: accepted, never issued
    cycle(0, 0, '0, '0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 5'd0, 5'd0);
    check_eq("r0_We", We, 1'b0);
    idle('0, '0);

    // Mid-op reset: accept under Clr drops the write and all busy bits
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd12, '0, '0);
    cycle(1, 1, 5'd6, 32'h66, 0, '0, '0, 0, '0, '0, '0);
    check_eq("midrst_We", We, 1'b0);
    sweep_busy();

    // Randomized traffic; requesters hold reg/data while waiting
    av = 0; bv = 0; ar = '0; br = '0; ad = '0; bd = '0;
    for (int n = 0; n < 3000; n++) begin
      bit clr;
      clr = ($urandom_range(199) == 0);
      if (!(av && !last_ga)) begin
        av = ($urandom_range(2) != 0);
        ar = AW'($urandom);
        ad = $urandom;
      end
      if (!(bv && !last_gb)) begin
        bv = ($urandom_range(2) != 0);
        br = AW'($urandom);
        bd = $urandom;
      end
      cycle(clr, av, ar, ad, bv, br, bd, ($urandom_range(2) == 0), AW'($urandom),
            AW'($urandom), AW'($urandom));
      if (clr) begin
        av = 0; bv = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
